byte_serial_cmp_ctrl: RTL
=========================

Name: byte_serial_cmp_ctrl

Overview:
- Controller that sequences one 8-bit cascadable magnitude-compare slice over multi-byte operands.
- Works MSB byte first and chains the equal/greater flags between bytes.
- Latches two NBYTES-wide operands on a start handshake, runs one byte per clock, and reports eq/gt/lt with a done pulse.
- Sits between wide-operand producers (sort/search units) and the shared 8-bit compare datapath, replacing a full-width parallel comparator.

Parameters:
- NBYTES, 4, operand width in bytes (legal 1..16).
- SW, 5, width of the steps output; must satisfy 2^SW > NBYTES.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  8*NBYTES  operand A, unsigned, byte NBYTES-1 is most significant.
- b_in  input  8*NBYTES  operand B, same format.
- busy  output  1  high while in CMP.
- done  output  1  one-cycle pulse when the result is valid.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- steps  output  SW  number of byte compares performed for the last result.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, eq=0, gt=0, lt=0, steps=0.
  - Operand registers, index and chain flags are cleared.
- States: IDLE, CMP.
- IDLE:
  - start=1 at a rising edge latches a_in/b_in, sets idx=NBYTES-1, e_acc=1, g_acc=0, steps=0, done=0, and moves to CMP. busy=1 from that edge.
  - start=0 holds in IDLE with eq/gt/lt/steps retained.
- CMP, per edge, on bytes a_r[idx], b_r[idx]:
  - e_nxt = e_acc & (a_byte == b_byte).
  - g_nxt = g_acc | (e_acc & (a_byte > b_byte)).
  - steps increments by 1.
  - Terminate when idx==0, or under the early-exit rule below. Otherwise idx decrements and the state stays CMP.
- Termination edge:
  - eq=e_nxt, gt=g_nxt, lt=~e_nxt & ~g_nxt.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Invariant: after any done, exactly one of eq/gt/lt is 1.
- Latency: with full run, done is high in the cycle NBYTES clocks after the start-accept edge.
- start while in CMP is ignored; no queueing.
- Input changes on a_in/b_in after the accept edge have no effect on the running compare.
- start held high continuously:
  - The cycle carrying done is an IDLE cycle, so start is re-accepted at the next edge.
  - Back-to-back throughput is one op per NBYTES+1 cycles (full run).
- NBYTES=1: one CMP cycle; done 1 clock after accept.
- All arithmetic is unsigned, byte-wise. steps never exceeds NBYTES.

Optional Feature:
- Macro: BYTE_CMP_EARLY_EXIT_EN.
- Defined:
  - CMP also terminates on the first edge where e_nxt=0, since lower bytes cannot change the result.
  - Results are taken from that edge; steps equals the index distance to the first differing byte plus 1.
  - Latency is variable: 1..NBYTES.
- Undefined:
  - Always runs the full NBYTES steps; latency is constant at NBYTES; steps=NBYTES on every result.
  - Final eq/gt/lt are identical to the defined case for the same operands.

Test Plan:
- Reset (NBYTES=4): rst_n low mid-CMP -> busy/done/eq/gt/lt/steps all 0 immediately, not waiting for a clock edge. After release, IDLE with start=0 -> outputs stay 0.
- A=0x12345678, B=0x12345678 -> done 4 clocks after accept; eq=1, gt=0, lt=0, steps=4. Same in both macro builds.
- A=0x80000000, B=0x00000000:
  - With EN: done 1 clock after accept; gt=1, steps=1.
  - Without EN: done after 4; gt=1, steps=4.
- A=0x000000FF, B=0x00000100:
  - With EN: lt=1, steps=3.
  - Without EN: lt=1, steps=4.
  - gt=0 and eq=0 in both builds.
- Busy and back-to-back: pulse start during CMP with different operands -> ignored, first result unchanged. Then hold start=1 with A=5, B=5 then A=6, B=5 -> two done pulses 5 cycles apart (no EN); results eq=1, then gt=1.
- Operand stability: change a_in every cycle after the accept edge -> result reflects the latched values only.

Source files
------------

// File: rtl/byte_serial_cmp_ctrl.sv
// Byte-serial magnitude comparator controller: walks two NBYTES-wide operands MSB byte first.
// Optional early exit on the first differing byte is enabled by defining BYTE_CMP_EARLY_EXIT_EN.
module byte_serial_cmp_ctrl #(
    parameter int NBYTES = 4,
    parameter int SW     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    output logic                  busy,
    output logic                  done,
    output logic                  eq,
    output logic                  gt,
    output logic                  lt,
    output logic [SW-1:0]         steps
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t                state_reg;
    logic [8*NBYTES-1:0]   a_reg;
    logic [8*NBYTES-1:0]   b_reg;
    logic [IW-1:0]         idx_reg;
    logic                  e_acc_reg;
    logic                  g_acc_reg;

    logic [7:0]            a_byte_arr [NBYTES];
    logic [7:0]            b_byte_arr [NBYTES];
    logic [7:0]            a_byte;
    logic [7:0]            b_byte;
    logic                  e_next;
    logic                  g_next;
    logic                  last_step;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
            assign a_byte_arr[gi] = a_reg[8*gi +: 8];
            assign b_byte_arr[gi] = b_reg[8*gi +: 8];
        end
    endgenerate

    assign a_byte = a_byte_arr[idx_reg];
    assign b_byte = b_byte_arr[idx_reg];

    // Chained cascade: once a higher byte differs, lower bytes cannot alter the verdict.
    assign e_next = e_acc_reg & (a_byte == b_byte);
    assign g_next = g_acc_reg | (e_acc_reg & (a_byte > b_byte));

`ifdef BYTE_CMP_EARLY_EXIT_EN
    assign last_step = (idx_reg == '0) || !e_next;
`else
    assign last_step = (idx_reg == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            e_acc_reg <= 1'b0;
            g_acc_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            steps     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a_in;
                        b_reg     <= b_in;
                        idx_reg   <= IW'(NBYTES - 1);
                        e_acc_reg <= 1'b1;
                        g_acc_reg <= 1'b0;
                        steps     <= '0;
                        busy      <= 1'b1;
                        state_reg <= CMP;
                    end
                end
                CMP: begin
                    e_acc_reg <= e_next;
                    g_acc_reg <= g_next;
                    steps     <= steps + SW'(1);
                    if (last_step) begin
                        eq        <= e_next;
                        gt        <= g_next;
                        lt        <= ~e_next & ~g_next;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        idx_reg <= idx_reg - IW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
